// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: ALU control codes, FSM states
// and default datapath width.
package mips_pkg;

    localparam logic [4:0] ALU_MULT  = 5'd15;
    localparam logic [4:0] ALU_MULTU = 5'd16;
    localparam logic [4:0] ALU_DIV   = 5'd17;
    localparam logic [4:0] ALU_DIVU  = 5'd18;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = $clog2(MD_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } md_state_t;

    function automatic logic is_md_op(input logic [4:0] code);
        return code inside {[ALU_MULT:ALU_DIVU]};
    endfunction

    function automatic logic is_signed_op(input logic [4:0] code);
        return (code == ALU_MULT) || (code == ALU_DIV);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] dvd_in,
    input  logic [WIDTH-1:0] dvs_in,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] dvd_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The extra top bit of the trial subtraction acts as the borrow flag.
    assign shifted = {rem_in, dvd_in[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_in};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dvd_out = {dvd_in[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Optional exception-flush input enabled by defining MULT_DIV_ABORT_EN.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alu_ctrl_in,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
`ifdef MULT_DIV_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic [WIDTH-1:0] a_q, b_q, rem_q, dvd_q;
    logic             sgn_q, neg_quot_q, neg_rem_q, dz_q;

    logic             abort_w;
    logic             accept, in_signed, in_div;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH-1:0] rem_nx, dvd_sh, quot, remd;
    logic             q_bit;

`ifdef MULT_DIV_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign in_signed = is_signed_op(alu_ctrl_in);
    assign in_div    = (alu_ctrl_in == ALU_DIV) || (alu_ctrl_in == ALU_DIVU);
    assign accept    = (state_q == IDLE) && start && is_md_op(alu_ctrl_in) && !abort_w;

    assign mag_a = (in_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign mag_b = (in_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    // Extending both operands to 2*WIDTH makes one multiplier serve both signednesses.
    assign ext_a = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = ext_a * ext_b;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in (rem_q),
        .dvd_in (dvd_q),
        .dvs_in (b_q),
        .rem_out(rem_nx),
        .dvd_out(dvd_sh),
        .q_bit  (q_bit)
    );

    assign quot = neg_quot_q ? -dvd_q : dvd_q;
    assign remd = neg_rem_q  ? -rem_q : rem_q;

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && abort_w) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                        if (accept) begin
                            state_q <= in_div ? DIV : MUL;
                            cnt_q   <= '0;
                        end
                    end
                    MUL: begin
                        {hi_q, lo_q} <= prod;
                        done_q       <= 1'b1;
                        state_q      <= IDLE;
                    end
                    DIV: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ITER) state_q <= FIN;
                    end
                    FIN: begin
                        hi_q    <= dz_q ? a_q : remd;
                        lo_q    <= dz_q ? '1  : quot;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // NOTE: operand/iteration registers need no reset; they are always loaded on
    // acceptance before anything reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q        <= op_a;
            sgn_q      <= in_signed;
            b_q        <= in_div ? mag_b : op_b;
            dvd_q      <= mag_a;
            rem_q      <= '0;
            neg_quot_q <= in_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_rem_q  <= in_signed && op_a[WIDTH-1];
            dz_q       <= (op_b == '0);
        end else if (state_q == DIV) begin
            rem_q <= rem_nx;
            dvd_q <= dvd_sh | WIDTH'(q_bit);
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus multi-cycle corner sequences.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, hi_we, lo_we;
    logic [4:0]   alu_ctrl_in;
    logic [W-1:0] op_a, op_b, wdata;
`ifdef MULT_DIV_ABORT_EN
    logic         abort;
`endif
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alu_ctrl_in(alu_ctrl_in),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .wdata      (wdata),
`ifdef MULT_DIV_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [4:0]   code;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        int           exp_cyc;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [4:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; alu_ctrl_in = code; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        start = 1'b0; alu_ctrl_in = 5'd0; op_a = $urandom; op_b = $urandom;
    endtask

    // Counts busy cycles; returns at the negedge of the first idle cycle.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
        end
    endtask

    int cyc;

    initial begin
        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        alu_ctrl_in = 5'd0; op_a = '0; op_b = '0; wdata = '0;
`ifdef MULT_DIV_ABORT_EN
        abort = 1'b0;
`endif
        vecs[0]  = '{5'd15, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1};
        vecs[1]  = '{5'd16, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 1};
        vecs[2]  = '{5'd17, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3]  = '{5'd18, 32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[4]  = '{5'd18, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 33};
        vecs[5]  = '{5'd17, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[6]  = '{5'd17, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
        vecs[7]  = '{5'd17, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 33};
        vecs[8]  = '{5'd15, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1};
        vecs[9]  = '{5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1};
        vecs[10] = '{5'd18, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 33};

        // Reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset = 1'b0;

        // MTHI / MTLO in idle
        hi_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1; hi_we = 1'b0;
        @(negedge clk);
        check("mthi_hi", hi, 32'h00001234);
        lo_we = 1'b1; wdata = 32'h5678;
        @(posedge clk); #1; lo_we = 1'b0;
        @(negedge clk);
        check("mtlo_lo", lo, 32'h00005678);
        check("mtlo_hi_kept", hi, 32'h00001234);
        check("mtlo_no_done", done, 0);

        // Table-driven operations
        for (int i = 0; i < 11; i++) begin
            start_op(vecs[i].code, vecs[i].a, vecs[i].b);
            wait_done(cyc);
            check($sformatf("vec%0d_busy_cycles", i), cyc, vecs[i].exp_cyc);
            check($sformatf("vec%0d_done", i), done, 1);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), done, 0);
        end

        // Unsupported code 13 is ignored
        start = 1'b1; alu_ctrl_in = 5'd13; op_a = 32'd5; op_b = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check("bad_code_busy", busy, 0);
        check("bad_code_done", done, 0);

        // Start in the done cycle is accepted
        start_op(5'd15, 32'hFFFFFFFE, 32'd3);
        wait_done(cyc);
        check("b2b_first_done", done, 1);
        start = 1'b1; alu_ctrl_in = 5'd16; op_a = 32'hFFFFFFFE; op_b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        wait_done(cyc);
        check("b2b_second_cycles", cyc, 1);
        check("b2b_second_hi", hi, 32'h00000002);
        check("b2b_second_done", done, 1);

        // Write accepted with start; result later overwrites it
        @(negedge clk);
        start = 1'b1; alu_ctrl_in = 5'd16; op_a = 32'd5; op_b = 32'd6;
        hi_we = 1'b1; wdata = 32'hABCD;
        @(posedge clk); #1; start = 1'b0; hi_we = 1'b0;
        @(negedge clk);
        check("same_edge_busy", busy, 1);
        check("same_edge_hi_written", hi, 32'h0000ABCD);
        @(negedge clk);
        check("same_edge_done", done, 1);
        check("same_edge_hi_result", hi, 0);
        check("same_edge_lo_result", lo, 32'd30);

        // Start and MTLO/MTHI during a divide are ignored
        start_op(5'd18, 32'd100, 32'd7);
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            if (cyc == 10) begin
                start = 1'b1; alu_ctrl_in = 5'd15; op_a = 32'd3; op_b = 32'd3;
                lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD;
            end else begin
                start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
            end
        end
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
        check("interlock_cycles", cyc, 33);
        check("interlock_done", done, 1);
        check("interlock_lo", lo, 32'd14);
        check("interlock_hi", hi, 32'd2);
        @(negedge clk);
        check("interlock_no_restart", busy, 0);

        // Reset mid-divide
        start_op(5'd17, 32'hFFFFFFF9, 32'd2);
        repeat (10) @(negedge clk);
        check("midreset_busy_before", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", busy, 0);
        check("midreset_hi", hi, 0);
        check("midreset_lo", lo, 0);
        check("midreset_done", done, 0);
        repeat (30) @(negedge clk);
        check("midreset_no_late_done", done, 0);

`ifdef MULT_DIV_ABORT_EN
        // Abort mid-divide keeps prior HI/LO
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11;
        @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
        start_op(5'd18, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 32'h11);
        check("abort_lo", lo, 32'h11);
        // Abort on the same edge as start drops the start
        start = 1'b1; abort = 1'b1; alu_ctrl_in = 5'd15; op_a = 32'd2; op_b = 32'd2;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_start_dropped", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
